// File: rtl/irda_dma_master.sv
// irda_dma_master: Wishbone DMA master moving words between memory and the IrDA core FIFO.
// Define IRDA_DMA_BUS_ERR_EN to let wbm_err_i abort the active channel and pulse bus_err_o.
module irda_dma_master #(
   parameter logic [31:0] IRDA_FIFO_ADR = 32'h0000_0000,
   parameter int unsigned CNT_W         = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   output logic [31:0]      wbm_adr_o,
   output logic [31:0]      wbm_dat_o,
   input  logic [31:0]      wbm_dat_i,
   output logic             wbm_we_o,
   output logic             wbm_stb_o,
   output logic             wbm_cyc_o,
   output logic [3:0]       wbm_sel_o,
   input  logic             wbm_ack_i,
   input  logic             wbm_err_i,
   input  logic             dma_req_t_i,
   output logic             dma_ack_t_o,
   input  logic             dma_req_r_i,
   output logic             dma_ack_r_o,
   input  logic             tx_start_i,
   input  logic [31:0]      tx_addr_i,
   input  logic [CNT_W-1:0] tx_cnt_i,
   input  logic             rx_start_i,
   input  logic [31:0]      rx_addr_i,
   input  logic [CNT_W-1:0] rx_cnt_i,
   output logic             tx_done_o,
   output logic             rx_done_o,
   output logic             tx_busy_o,
   output logic             rx_busy_o,
   output logic             bus_err_o
);

   typedef enum logic [2:0] {IDLE, TX_RD, TX_WR, RX_RD, RX_WR, ACK} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic             cyc_q, cyc_d;
   logic             we_q, we_d;
   logic [31:0]      adr_q, adr_d;
   logic [31:0]      dat_q, dat_d;
   logic [31:0]      txPtr_q, txPtr_d, rxPtr_q, rxPtr_d;
   logic [CNT_W-1:0] txCnt_q, txCnt_d, rxCnt_q, rxCnt_d;
   logic             txBusy_q, txBusy_d, rxBusy_q, rxBusy_d;
   logic             txDone_q, txDone_d, rxDone_q, rxDone_d;
   logic             ackT_q, ackT_d, ackR_q, ackR_d;
   logic             busErr_q, busErr_d;
   logic             errTerm, errAbort, txWord;

`ifdef IRDA_DMA_BUS_ERR_EN
   assign errTerm = wbm_err_i;
`else
   // Error input has no effect in this build; the AND only keeps the port referenced.
   assign errTerm = 1'b0 & wbm_err_i;
`endif

   assign txWord   = (state_q == TX_RD) || (state_q == TX_WR);
   assign errAbort = cyc_q && errTerm && !wbm_ack_i;

   always_comb begin
      state_d  = state_q;
      cyc_d    = cyc_q;
      we_d     = we_q;
      adr_d    = adr_q;
      dat_d    = dat_q;
      txPtr_d  = txPtr_q;
      txCnt_d  = txCnt_q;
      rxPtr_d  = rxPtr_q;
      rxCnt_d  = rxCnt_q;
      txBusy_d = txBusy_q;
      rxBusy_d = rxBusy_q;
      txDone_d = 1'b0;
      rxDone_d = 1'b0;
      ackT_d   = 1'b0;
      ackR_d   = 1'b0;
      busErr_d = 1'b0;

      if (tx_start_i && !txBusy_q) begin
         if (tx_cnt_i != '0) begin
            txPtr_d  = tx_addr_i;
            txCnt_d  = tx_cnt_i;
            txBusy_d = 1'b1;
         end else begin
            txDone_d = 1'b1;
         end
      end
      if (rx_start_i && !rxBusy_q) begin
         if (rx_cnt_i != '0) begin
            rxPtr_d  = rx_addr_i;
            rxCnt_d  = rx_cnt_i;
            rxBusy_d = 1'b1;
         end else begin
            rxDone_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (rxBusy_q && dma_req_r_i) begin
               state_d = RX_RD;
               cyc_d   = 1'b1;
               we_d    = 1'b0;
               adr_d   = IRDA_FIFO_ADR;
            end else if (txBusy_q && dma_req_t_i) begin
               state_d = TX_RD;
               cyc_d   = 1'b1;
               we_d    = 1'b0;
               adr_d   = txPtr_q;
            end
         end
         TX_RD, RX_RD: begin
            if (cyc_q && wbm_ack_i) begin
               cyc_d   = 1'b0;
               dat_d   = wbm_dat_i;
               state_d = txWord ? TX_WR : RX_WR;
            end
         end
         TX_WR, RX_WR: begin
            // Entered with cyc low, which gives the mandatory idle cycle between read and write.
            if (!cyc_q) begin
               cyc_d = 1'b1;
               we_d  = 1'b1;
               adr_d = txWord ? IRDA_FIFO_ADR : rxPtr_q;
            end else if (wbm_ack_i) begin
               cyc_d   = 1'b0;
               we_d    = 1'b0;
               state_d = ACK;
               if (txWord) begin
                  ackT_d  = 1'b1;
                  txPtr_d = txPtr_q + 32'd4;
                  txCnt_d = txCnt_q - CNT_ONE;
                  if (txCnt_q == CNT_ONE) begin
                     txDone_d = 1'b1;
                     txBusy_d = 1'b0;
                  end
               end else begin
                  ackR_d  = 1'b1;
                  rxPtr_d = rxPtr_q + 32'd4;
                  rxCnt_d = rxCnt_q - CNT_ONE;
                  if (rxCnt_q == CNT_ONE) begin
                     rxDone_d = 1'b1;
                     rxBusy_d = 1'b0;
                  end
               end
            end
         end
         ACK:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (errAbort) begin
         state_d  = IDLE;
         cyc_d    = 1'b0;
         we_d     = 1'b0;
         busErr_d = 1'b1;
         if (txWord) txBusy_d = 1'b0;
         else        rxBusy_d = 1'b0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q  <= IDLE;
         cyc_q    <= 1'b0;
         we_q     <= 1'b0;
         adr_q    <= '0;
         dat_q    <= '0;
         txPtr_q  <= '0;
         txCnt_q  <= '0;
         rxPtr_q  <= '0;
         rxCnt_q  <= '0;
         txBusy_q <= 1'b0;
         rxBusy_q <= 1'b0;
         txDone_q <= 1'b0;
         rxDone_q <= 1'b0;
         ackT_q   <= 1'b0;
         ackR_q   <= 1'b0;
         busErr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         we_q     <= we_d;
         adr_q    <= adr_d;
         dat_q    <= dat_d;
         txPtr_q  <= txPtr_d;
         txCnt_q  <= txCnt_d;
         rxPtr_q  <= rxPtr_d;
         rxCnt_q  <= rxCnt_d;
         txBusy_q <= txBusy_d;
         rxBusy_q <= rxBusy_d;
         txDone_q <= txDone_d;
         rxDone_q <= rxDone_d;
         ackT_q   <= ackT_d;
         ackR_q   <= ackR_d;
         busErr_q <= busErr_d;
      end
   end

   assign wbm_adr_o   = adr_q;
   assign wbm_dat_o   = dat_q;
   assign wbm_we_o    = we_q;
   assign wbm_cyc_o   = cyc_q;
   assign wbm_stb_o   = cyc_q;
   assign wbm_sel_o   = 4'hF;
   assign dma_ack_t_o = ackT_q;
   assign dma_ack_r_o = ackR_q;
   assign tx_done_o   = txDone_q;
   assign rx_done_o   = rxDone_q;
   assign tx_busy_o   = txBusy_q;
   assign rx_busy_o   = rxBusy_q;
   assign bus_err_o   = busErr_q;

endmodule

// File: tb/tb_irda_dma_master.sv
// tb_irda_dma_master: randomized bench with a Wishbone slave/memory model and pulse monitor.
// Build with IRDA_DMA_BUS_ERR_EN defined to exercise the error-abort behaviour.
module tb_irda_dma_master;

   localparam logic [31:0] FIFO_ADR = 32'h0000_0000;
   localparam int          CNT_W    = 16;

   logic             clk = 1'b0;
   logic             wb_rst_i = 1'b1;
   logic [31:0]      wbm_adr_o, wbm_dat_o;
   logic [31:0]      wbm_dat_i = '0;
   logic             wbm_we_o, wbm_stb_o, wbm_cyc_o;
   logic [3:0]       wbm_sel_o;
   logic             wbm_ack_i = 1'b0, wbm_err_i = 1'b0;
   logic             dma_req_t_i = 1'b0, dma_req_r_i = 1'b0;
   logic             dma_ack_t_o, dma_ack_r_o;
   logic             tx_start_i = 1'b0, rx_start_i = 1'b0;
   logic [31:0]      tx_addr_i = '0, rx_addr_i = '0;
   logic [CNT_W-1:0] tx_cnt_i = '0, rx_cnt_i = '0;
   logic             tx_done_o, rx_done_o, tx_busy_o, rx_busy_o, bus_err_o;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   irda_dma_master #(.IRDA_FIFO_ADR(FIFO_ADR), .CNT_W(CNT_W)) dut (
      .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
      .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
      .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
      .wbm_sel_o(wbm_sel_o), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
      .dma_req_t_i(dma_req_t_i), .dma_ack_t_o(dma_ack_t_o),
      .dma_req_r_i(dma_req_r_i), .dma_ack_r_o(dma_ack_r_o),
      .tx_start_i(tx_start_i), .tx_addr_i(tx_addr_i), .tx_cnt_i(tx_cnt_i),
      .rx_start_i(rx_start_i), .rx_addr_i(rx_addr_i), .rx_cnt_i(rx_cnt_i),
      .tx_done_o(tx_done_o), .rx_done_o(rx_done_o),
      .tx_busy_o(tx_busy_o), .rx_busy_o(rx_busy_o), .bus_err_o(bus_err_o)
   );

   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
   } busEnt_t;

   busEnt_t     busLog[$];
   logic [31:0] txOut[$];
   logic [31:0] srcMem [logic [31:0]];
   logic [31:0] dstMem [logic [31:0]];
   logic [31:0] rxFifoData [int];
   logic [31:0] rdData;
   int          rxRdIdx = 0;
   int          slvWait = 0;
   int          errReq = 0;
   int          errDone = 0;
   int          waitCnt = 0;

   // Registered slave: answers slvWait cycles after the first edge that sees stb.
   always @(posedge clk) begin
      if (wb_rst_i) begin
         wbm_ack_i <= 1'b0;
         wbm_err_i <= 1'b0;
         waitCnt   <= 0;
      end else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i) begin
         if (waitCnt >= slvWait) begin
            waitCnt <= 0;
            if (errReq > errDone) begin
               wbm_err_i <= 1'b1;
               errDone   <= errDone + 1;
            end else begin
               wbm_ack_i <= 1'b1;
               if (wbm_we_o) begin
                  if (wbm_adr_o == FIFO_ADR) txOut.push_back(wbm_dat_o);
                  else dstMem[wbm_adr_o] = wbm_dat_o;
                  busLog.push_back({1'b1, wbm_adr_o, wbm_dat_o});
               end else begin
                  if (wbm_adr_o == FIFO_ADR) begin
                     rdData = rxFifoData.exists(rxRdIdx) ? rxFifoData[rxRdIdx] : 32'hBAD0_0000;
                     rxRdIdx = rxRdIdx + 1;
                  end else begin
                     rdData = srcMem.exists(wbm_adr_o) ? srcMem[wbm_adr_o] : ~wbm_adr_o;
                  end
                  wbm_dat_i <= rdData;
                  busLog.push_back({1'b0, wbm_adr_o, rdData});
               end
            end
         end else begin
            waitCnt <= waitCnt + 1;
         end
      end else begin
         wbm_ack_i <= 1'b0;
         wbm_err_i <= 1'b0;
         if (!(wbm_cyc_o && wbm_stb_o)) waitCnt <= 0;
      end
   end

   int  ackTCnt = 0, ackRCnt = 0, txDoneCnt = 0, rxDoneCnt = 0, busErrCnt = 0, cycHighCnt = 0;
   int  txDoneWithAck = 0, rxDoneWithAck = 0;
   byte ackOrder[$];

   // Pulse monitor sampling on the falling edge.
   always @(negedge clk) begin
      if (dma_ack_t_o === 1'b1) begin ackTCnt++; ackOrder.push_back("T"); end
      if (dma_ack_r_o === 1'b1) begin ackRCnt++; ackOrder.push_back("R"); end
      if (tx_done_o === 1'b1) txDoneCnt++;
      if (rx_done_o === 1'b1) rxDoneCnt++;
      if (tx_done_o === 1'b1 && dma_ack_t_o === 1'b1) txDoneWithAck++;
      if (rx_done_o === 1'b1 && dma_ack_r_o === 1'b1) rxDoneWithAck++;
      if (bus_err_o === 1'b1) busErrCnt++;
      if (wbm_cyc_o === 1'b1) cycHighCnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      @(posedge clk); #1;
      wb_rst_i = 1'b1;
      tx_start_i = 1'b0; rx_start_i = 1'b0;
      dma_req_t_i = 1'b0; dma_req_r_i = 1'b0;
      tick(2);
      wb_rst_i = 1'b0;
   endtask

   task automatic armTx(input logic [31:0] a, input int c);
      @(posedge clk); #1;
      tx_start_i = 1'b1; tx_addr_i = a; tx_cnt_i = CNT_W'(c);
      @(posedge clk); #1;
      tx_start_i = 1'b0;
   endtask

   task automatic armRx(input logic [31:0] a, input int c);
      @(posedge clk); #1;
      rx_start_i = 1'b1; rx_addr_i = a; rx_cnt_i = CNT_W'(c);
      @(posedge clk); #1;
      rx_start_i = 1'b0;
   endtask

   task automatic waitDone(input int txT, input int rxT, input int maxCyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxCyc; i++) begin
         if (txDoneCnt >= txT && rxDoneCnt >= rxT) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      logic [9:0] ctl;
      wb_rst_i = 1'b1;
      tick(3);
      ctl = {wbm_cyc_o, wbm_stb_o, wbm_we_o, dma_ack_t_o, dma_ack_r_o,
             tx_done_o, rx_done_o, tx_busy_o, rx_busy_o, bus_err_o};
      vectors++;
      if (ctl !== 10'b0) begin miscompares++; $display("[TB] FAIL reset_ctrl: got %b expected %b", ctl, 10'b0); end
      vectors++;
      if (wbm_adr_o !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_adr: got %h expected 0", wbm_adr_o); end
      vectors++;
      if (wbm_dat_o !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_dat: got %h expected 0", wbm_dat_o); end
      vectors++;
      if (wbm_sel_o !== 4'hF) begin miscompares++; $display("[TB] FAIL reset_sel: got %h expected f", wbm_sel_o); end
      wb_rst_i = 1'b0;
   endtask

   task automatic test_tx_basic();
      logic [31:0] d0, d1;
      busEnt_t     exp [4];
      busEnt_t     got;
      int          lb, aT, dT, dA;
      bit          ok;
      applyReset();
      slvWait = 1;
      d0 = $urandom; d1 = $urandom;
      srcMem[32'h100] = d0; srcMem[32'h104] = d1;
      exp[0] = {1'b0, 32'h100, d0};  exp[1] = {1'b1, FIFO_ADR, d0};
      exp[2] = {1'b0, 32'h104, d1};  exp[3] = {1'b1, FIFO_ADR, d1};
      lb = busLog.size(); aT = ackTCnt; dT = txDoneCnt; dA = txDoneWithAck;
      armTx(32'h100, 2);
      vectors++;
      if (tx_busy_o !== 1'b1) begin miscompares++; $display("[TB] FAIL tx_busy_set: got %b expected 1", tx_busy_o); end
      dma_req_t_i = 1'b1;
      waitDone(dT + 1, 0, 300, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("[TB] FAIL tx_done_timeout: got no done expected done"); end
      dma_req_t_i = 1'b0;
      tick(3);
      for (int i = 0; i < 4; i++) begin
         got = (lb + i < busLog.size()) ? busLog[lb + i] : '0;
         vectors++;
         if (got !== exp[i]) begin
            miscompares++;
            $display("[TB] FAIL tx_bus%0d: got we=%b adr=%h dat=%h expected we=%b adr=%h dat=%h",
                     i, got.we, got.adr, got.dat, exp[i].we, exp[i].adr, exp[i].dat);
         end
      end
      vectors++;
      if (ackTCnt - aT !== 2) begin miscompares++; $display("[TB] FAIL tx_ack_count: got %0d expected 2", ackTCnt - aT); end
      vectors++;
      if (txDoneWithAck - dA !== 1 || txDoneCnt - dT !== 1) begin
         miscompares++; $display("[TB] FAIL tx_done_with_ack: got %0d/%0d expected 1/1", txDoneWithAck - dA, txDoneCnt - dT);
      end
      vectors++;
      if (tx_busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL tx_busy_clear: got %b expected 0", tx_busy_o); end
   endtask

   task automatic test_rx_basic();
      busEnt_t got;
      int      lb, aR, dR, dA;
      bit      ok;
      applyReset();
      slvWait = $urandom_range(0, 2);
      rxFifoData[rxRdIdx] = 32'hDEADBEEF;
      lb = busLog.size(); aR = ackRCnt; dR = rxDoneCnt; dA = rxDoneWithAck;
      armRx(32'h200, 1);
      vectors++;
      if (rx_busy_o !== 1'b1) begin miscompares++; $display("[TB] FAIL rx_busy_set: got %b expected 1", rx_busy_o); end
      dma_req_r_i = 1'b1;
      waitDone(0, dR + 1, 300, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("[TB] FAIL rx_done_timeout: got no done expected done"); end
      dma_req_r_i = 1'b0;
      tick(3);
      got = (lb + 1 < busLog.size()) ? busLog[lb + 1] : '0;
      vectors++;
      if (got !== {1'b1, 32'h200, 32'hDEADBEEF}) begin
         miscompares++; $display("[TB] FAIL rx_write: got we=%b adr=%h dat=%h expected we=1 adr=00000200 dat=deadbeef", got.we, got.adr, got.dat);
      end
      vectors++;
      if (!dstMem.exists(32'h200) || dstMem[32'h200] !== 32'hDEADBEEF) begin
         miscompares++; $display("[TB] FAIL rx_mem: got %h expected deadbeef", dstMem.exists(32'h200) ? dstMem[32'h200] : 32'h0);
      end
      vectors++;
      if (ackRCnt - aR !== 1 || rxDoneWithAck - dA !== 1) begin
         miscompares++; $display("[TB] FAIL rx_ack_done: got %0d/%0d expected 1/1", ackRCnt - aR, rxDoneWithAck - dA);
      end
      vectors++;
      if (rx_busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rx_busy_clear: got %b expected 0", rx_busy_o); end
   endtask

   task automatic test_priority();
      logic [31:0] td, rd;
      int          ob, tb0, dT, dR;
      bit          ok;
      byte         first, second;
      applyReset();
      slvWait = $urandom_range(0, 2);
      td = $urandom; rd = $urandom;
      srcMem[32'h400] = td;
      rxFifoData[rxRdIdx] = rd;
      ob = ackOrder.size(); tb0 = txOut.size(); dT = txDoneCnt; dR = rxDoneCnt;
      @(posedge clk); #1;
      tx_start_i = 1'b1; tx_addr_i = 32'h400; tx_cnt_i = 1;
      rx_start_i = 1'b1; rx_addr_i = 32'h300; rx_cnt_i = 1;
      @(posedge clk); #1;
      tx_start_i = 1'b0; rx_start_i = 1'b0;
      dma_req_t_i = 1'b1; dma_req_r_i = 1'b1;
      waitDone(dT + 1, dR + 1, 400, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("[TB] FAIL prio_timeout: got no done expected both done"); end
      dma_req_t_i = 1'b0; dma_req_r_i = 1'b0;
      first  = (ob < ackOrder.size())     ? ackOrder[ob]     : 8'h3F;
      second = (ob + 1 < ackOrder.size()) ? ackOrder[ob + 1] : 8'h3F;
      vectors++;
      if (first !== "R" || second !== "T") begin
         miscompares++; $display("[TB] FAIL prio_order: got %c%c expected RT", first, second);
      end
      vectors++;
      if (tb0 >= txOut.size() || txOut[tb0] !== td) begin
         miscompares++; $display("[TB] FAIL prio_tx_data: got %h expected %h", (tb0 < txOut.size()) ? txOut[tb0] : 32'h0, td);
      end
      vectors++;
      if (!dstMem.exists(32'h300) || dstMem[32'h300] !== rd) begin
         miscompares++; $display("[TB] FAIL prio_rx_data: got %h expected %h", dstMem.exists(32'h300) ? dstMem[32'h300] : 32'h0, rd);
      end
   endtask

   task automatic test_zero_count();
      int cb, aT, aR;
      applyReset();
      @(posedge clk); #1;
      tx_start_i = 1'b1; tx_addr_i = 32'h500; tx_cnt_i = '0;
      @(posedge clk); #1;
      tx_start_i = 1'b0;
      vectors++;
      if ({tx_done_o, tx_busy_o} !== 2'b10) begin
         miscompares++; $display("[TB] FAIL zero_cnt_done: got done/busy=%b expected 10", {tx_done_o, tx_busy_o});
      end
      tick(1);
      vectors++;
      if (tx_done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_cnt_pulse: got %b expected 0", tx_done_o); end
      cb = cycHighCnt; aT = ackTCnt; aR = ackRCnt;
      dma_req_t_i = 1'b1; dma_req_r_i = 1'b1;
      tick(20);
      dma_req_t_i = 1'b0; dma_req_r_i = 1'b0;
      vectors++;
      if (cycHighCnt - cb !== 0 || ackTCnt - aT !== 0 || ackRCnt - aR !== 0) begin
         miscompares++; $display("[TB] FAIL unarmed_req: got cyc=%0d ackT=%0d ackR=%0d expected 0/0/0",
                                 cycHighCnt - cb, ackTCnt - aT, ackRCnt - aR);
      end
   endtask

   task automatic test_latency();
      int n, lat;
      applyReset();
      slvWait = 0;
      srcMem[32'h600] = $urandom;
      armTx(32'h600, 1);
      dma_req_t_i = 1'b1;
      lat = -1;
      n = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         n++;
         #1;
         if (dma_ack_t_o === 1'b1) begin
            lat = n - 1;
            break;
         end
      end
      dma_req_t_i = 1'b0;
      // Edges after the one that first samples req, up to the one raising the ack.
      vectors++;
      if (lat !== 5) begin miscompares++; $display("[TB] FAIL latency: got %0d expected 5", lat); end
      tick(3);
   endtask

   task automatic test_random();
      logic [31:0] expTx[$];
      logic [31:0] expRx[$];
      logic [31:0] txBase, rxBase, v;
      int          ntx, nrx, ob, rb, aT, aR, dT, dR, mism;
      bit          ok;
      for (int it = 0; it < 6; it++) begin
         applyReset();
         slvWait = $urandom_range(0, 2);
         ntx = $urandom_range(1, 4);
         nrx = $urandom_range(1, 4);
         txBase = 32'h1000_0000 + (it << 8) + ($urandom_range(0, 15) << 2);
         rxBase = 32'h2000_0000 + (it << 8) + ($urandom_range(0, 15) << 2);
         expTx.delete(); expRx.delete();
         rb = rxRdIdx;
         for (int i = 0; i < ntx; i++) begin v = $urandom; srcMem[txBase + 32'(4 * i)] = v; expTx.push_back(v); end
         for (int i = 0; i < nrx; i++) begin v = $urandom; rxFifoData[rb + i] = v; expRx.push_back(v); end
         ob = txOut.size(); aT = ackTCnt; aR = ackRCnt; dT = txDoneCnt; dR = rxDoneCnt;
         armTx(txBase, ntx);
         dma_req_t_i = 1'b1;
         tick($urandom_range(0, 6));
         armRx(rxBase, nrx);
         dma_req_r_i = 1'b1;
         waitDone(dT + 1, dR + 1, 2000, ok);
         dma_req_t_i = 1'b0; dma_req_r_i = 1'b0;
         vectors++;
         if (!ok) begin miscompares++; $display("[TB] FAIL rand%0d_timeout: got no done expected both done", it); end
         mism = 0;
         for (int i = 0; i < ntx; i++) begin
            if (ob + i >= txOut.size() || txOut[ob + i] !== expTx[i]) mism++;
         end
         if (txOut.size() - ob != ntx) mism++;
         vectors++;
         if (mism != 0) begin miscompares++; $display("[TB] FAIL rand%0d_tx_stream: got %0d wrong words expected 0 (ntx=%0d)", it, mism, ntx); end
         mism = 0;
         for (int i = 0; i < nrx; i++) begin
            if (!dstMem.exists(rxBase + 32'(4 * i)) || dstMem[rxBase + 32'(4 * i)] !== expRx[i]) mism++;
         end
         vectors++;
         if (mism != 0) begin miscompares++; $display("[TB] FAIL rand%0d_rx_mem: got %0d wrong words expected 0 (nrx=%0d)", it, mism, nrx); end
         vectors++;
         if (ackTCnt - aT !== ntx || ackRCnt - aR !== nrx || txDoneCnt - dT !== 1 || rxDoneCnt - dR !== 1) begin
            miscompares++; $display("[TB] FAIL rand%0d_counts: got ackT=%0d ackR=%0d doneT=%0d doneR=%0d expected %0d/%0d/1/1",
                                    it, ackTCnt - aT, ackRCnt - aR, txDoneCnt - dT, rxDoneCnt - dR, ntx, nrx);
         end
         vectors++;
         if ({tx_busy_o, rx_busy_o} !== 2'b00) begin miscompares++; $display("[TB] FAIL rand%0d_busy: got %b expected 00", it, {tx_busy_o, rx_busy_o}); end
      end
   endtask

   task automatic test_reset_midword();
      int  aT, dT, ob;
      bit  seen;
      applyReset();
      slvWait = 3;
      srcMem[32'h800] = $urandom; srcMem[32'h804] = $urandom;
      aT = ackTCnt; dT = txDoneCnt; ob = txOut.size();
      armTx(32'h800, 2);
      dma_req_t_i = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (wbm_stb_o === 1'b1 && wbm_we_o === 1'b1) begin seen = 1'b1; break; end
      end
      vectors++;
      if (!seen) begin miscompares++; $display("[TB] FAIL midword_reach_write: got no write cycle expected write cycle"); end
      wb_rst_i = 1'b1;
      tick(1);
      vectors++;
      if ({wbm_cyc_o, wbm_stb_o, tx_busy_o} !== 3'b000) begin
         miscompares++; $display("[TB] FAIL midword_drop: got cyc/stb/busy=%b expected 000", {wbm_cyc_o, wbm_stb_o, tx_busy_o});
      end
      wb_rst_i = 1'b0;
      tick(10);
      dma_req_t_i = 1'b0;
      vectors++;
      if (ackTCnt - aT !== 0 || txDoneCnt - dT !== 0 || txOut.size() - ob !== 0) begin
         miscompares++; $display("[TB] FAIL midword_no_ack: got ack=%0d done=%0d fifo_writes=%0d expected 0/0/0",
                                 ackTCnt - aT, txDoneCnt - dT, txOut.size() - ob);
      end
   endtask

   task automatic test_bus_err();
      int aT, dT, be, ob;
      bit ok;
      applyReset();
      slvWait = 1;
      srcMem[32'h700] = $urandom; srcMem[32'h704] = $urandom;
      aT = ackTCnt; dT = txDoneCnt; be = busErrCnt; ob = txOut.size();
      errReq = errReq + 1;
      armTx(32'h700, 2);
      dma_req_t_i = 1'b1;
`ifdef IRDA_DMA_BUS_ERR_EN
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (busErrCnt > be) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      vectors++;
      if (!ok) begin miscompares++; $display("[TB] FAIL err_pulse_timeout: got no bus_err expected bus_err"); end
      tick(10);
      vectors++;
      if ({tx_busy_o, wbm_cyc_o} !== 2'b00) begin
         miscompares++; $display("[TB] FAIL err_abort: got busy/cyc=%b expected 00", {tx_busy_o, wbm_cyc_o});
      end
      vectors++;
      if (ackTCnt - aT !== 0 || txDoneCnt - dT !== 0 || busErrCnt - be !== 1) begin
         miscompares++; $display("[TB] FAIL err_counts: got ack=%0d done=%0d err=%0d expected 0/0/1",
                                 ackTCnt - aT, txDoneCnt - dT, busErrCnt - be);
      end
`else
      waitDone(dT + 1, 0, 400, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("[TB] FAIL noerr_timeout: got no done expected done"); end
      vectors++;
      if (ackTCnt - aT !== 2 || busErrCnt - be !== 0) begin
         miscompares++; $display("[TB] FAIL noerr_counts: got ack=%0d err=%0d expected 2/0", ackTCnt - aT, busErrCnt - be);
      end
      vectors++;
      if (txOut.size() - ob !== 2 || txOut[ob] !== srcMem[32'h700]) begin
         miscompares++; $display("[TB] FAIL noerr_data: got %0d words expected 2 starting with %h", txOut.size() - ob, srcMem[32'h700]);
      end
`endif
      dma_req_t_i = 1'b0;
      tick(2);
   endtask

   initial begin
      test_reset();
      test_tx_basic();
      test_rx_basic();
      test_priority();
      test_zero_count();
      test_latency();
      test_random();
      test_reset_midword();
      test_bus_err();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no completion expected completion within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/irda_dma_master.md
IRDA_DMA_MASTER -- requirements
Module: irda_dma_master

Interface
REQ-001 Parameter IRDA_FIFO_ADR, default 32'h0000_0000: bus address of the IrDA core FIFO data register (TX on write, RX on read).
REQ-002 Parameter CNT_W, default 16: width of the word-count inputs and counters.
REQ-003 wb_clk_i  in  1  single clock; all logic rising-edge.
REQ-004 wb_rst_i  in  1  synchronous, active-high reset.
REQ-005 wbm_adr_o  out  32 / wbm_dat_o  out  32 / wbm_dat_i  in  32: Wishbone master address, write data, read data.
REQ-006 wbm_we_o, wbm_stb_o, wbm_cyc_o  out  1 each; wbm_sel_o  out  4, constant 4'hF; wbm_ack_i, wbm_err_i  in  1 each.
REQ-007 dma_req_t_i  in  1: core requests a TX FIFO fill; dma_ack_t_o  out  1: one-cycle word-serviced pulse.
REQ-008 dma_req_r_i  in  1: core requests an RX FIFO drain; dma_ack_r_o  out  1: one-cycle word-serviced pulse.
REQ-009 tx_start_i  in  1, tx_addr_i  in  32, tx_cnt_i  in  CNT_W: arm TX channel (memory source, word count).
REQ-010 rx_start_i  in  1, rx_addr_i  in  32, rx_cnt_i  in  CNT_W: arm RX channel (memory destination, word count).
REQ-011 tx_done_o, rx_done_o  out  1: one-cycle completion pulses; tx_busy_o, rx_busy_o  out  1: channel armed; bus_err_o  out  1: error pulse.

Function
REQ-012 FSM states: IDLE, TX_RD, TX_WR, RX_RD, RX_WR, ACK.
REQ-013 start with cnt>0 while channel idle: latch addr/cnt, set busy next cycle; start while busy ignored; start with cnt=0: done pulse next cycle, busy stays 0.
REQ-014 In IDLE, service an armed channel whose req is high; both eligible -> RX wins; req on unarmed channel ignored (no ack).
REQ-015 TX word: TX_RD reads memory at tx pointer (we=0); data captured on ack; TX_WR writes captured data to IRDA_FIFO_ADR (we=1).
REQ-016 RX word: RX_RD reads IRDA_FIFO_ADR; RX_WR writes captured data to rx pointer.
REQ-017 cyc/stb asserted on entering a bus state and held with stable adr/dat/we until ack; cyc/stb deasserted for at least one cycle between the two cycles of a word.
REQ-018 After the write ack: ACK state for one cycle, pulse dma_ack_t_o or dma_ack_r_o, pointer += 4 (32-bit wrap), count -= 1, then IDLE.
REQ-019 Count reaching 0 in ACK: done pulse in the same cycle as the dma ack; busy clears.
REQ-020 Minimum latency req -> ack: 5 cycles with zero-wait-state slaves (ack in the cycle after stb).
REQ-021 Starting one channel while the other transfers does not disturb the ongoing word.

Reset
REQ-022 On wb_rst_i: FSM to IDLE; cyc, stb, we, all acks, done, busy, bus_err_o to 0; pointers and counts to 0; wbm_adr_o/wbm_dat_o to 0.
REQ-023 Reset asserted mid-word drops cyc/stb on the next edge; no dma ack or done is issued for the aborted word.

Configuration
REQ-024 Macro IRDA_DMA_BUS_ERR_EN defined: wbm_err_i terminates a bus cycle like ack, aborts the active channel (busy 0, no dma ack, no done), pulses bus_err_o one cycle, FSM to IDLE.
REQ-025 Macro undefined: wbm_err_i ignored, bus cycles end only on ack, bus_err_o constant 0.

Verification
REQ-026 TX armed addr 0x100, cnt 2; req_t held; slave ack 1-wait -> reads 0x100, 0x104, FIFO writes of the same data, two dma_ack_t pulses, tx_done with the second.
REQ-027 RX armed addr 0x200, cnt 1; req_r high; FIFO returns 0xDEADBEEF -> write 0xDEADBEEF to 0x200, dma_ack_r pulse, rx_done, rx_busy 0.
REQ-028 Both armed, req_t and req_r rise same cycle -> RX word serviced first, then TX.
REQ-029 tx_cnt=0 start -> tx_done next cycle, no bus activity; req_t on unarmed channel -> no cyc, no ack.
REQ-030 Reset during TX_WR with stb high -> cyc/stb 0 next cycle, no ack, busy 0.
REQ-031 With IRDA_DMA_BUS_ERR_EN: err on TX_RD -> bus_err_o pulse, tx_busy 0, no dma_ack_t; without the macro, same stimulus -> waits for ack.
